notation_arbiter: RTL and testbench

//  Shares one binary-to-decimal notation converter between N_REQ requesters.

---
 rtl/notation_arbiter_if.sv | 56 +++++
 rtl/notation_arbiter.sv | 116 +++++++++++
 tb/tb_notation_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/notation_arbiter_if.sv
// Requester-side and converter-side bundles for notation_arbiter.
// Requesters drive the master modport; the converter drives the conv slave.
interface notation_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int DIG_W = 24
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_number;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       resp_valid;
  logic [DIG_W-1:0]       resp_digits;
  logic                   resp_error;

  modport master (
    output req_valid,
    output req_number,
    input  req_ready,
    input  resp_valid,
    input  resp_digits,
    input  resp_error
  );

  modport slave (
    input  req_valid,
    input  req_number,
    output req_ready,
    output resp_valid,
    output resp_digits,
    output resp_error
  );
endinterface

interface notation_conv_if #(
  parameter int WIDTH = 8,
  parameter int DIG_W = 24
);
  logic             restart;
  logic [WIDTH-1:0] number;
  logic [DIG_W-1:0] digits;
  logic             done;

  modport master (
    output restart,
    output number,
    input  digits,
    input  done
  );

  modport slave (
    input  restart,
    input  number,
    output digits,
    output done
  );
endinterface

// File: rtl/notation_arbiter.sv
// Round-robin arbiter sharing one binary-to-decimal converter.
// IDLE -> LOAD (restart) -> WAIT (done/timeout) -> RESP -> IDLE.
module notation_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int DIG_W   = 24,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  notation_arbiter_if.slave req,
  notation_conv_if.master   conv,
  output logic              busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    RESP
  } state_t;

  state_t         state;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  winner;
  logic [TW-1:0]  timer;
  logic           grant_hit;
  logic [PW-1:0]  grant_idx;
  logic [PW:0]    rr_sum;
  logic [PW-1:0]  rr_idx;
  logic [N_REQ-1:0] winner_oh;

  // Walk backwards so the first hit in ptr order is the last written.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    rr_sum    = '0;
    rr_idx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      rr_sum = {1'b0, ptr} + (PW+1)'(k);
      if (rr_sum >= (PW+1)'(N_REQ))
        rr_sum = rr_sum - (PW+1)'(N_REQ);
      rr_idx = rr_sum[PW-1:0];
      if (req.req_valid[rr_idx]) begin
        grant_hit = 1'b1;
        grant_idx = rr_idx;
      end
    end
  end

  always_comb begin
    req.req_ready = '0;
    if (state == IDLE && grant_hit)
      req.req_ready[grant_idx] = 1'b1;
  end

  assign winner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << winner;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      ptr             <= '0;
      winner          <= '0;
      timer           <= '0;
      busy            <= 1'b0;
      conv.restart    <= 1'b0;
      conv.number     <= '0;
      req.resp_valid  <= '0;
      req.resp_digits <= '0;
      req.resp_error  <= 1'b0;
    end else begin
      conv.restart   <= 1'b0;
      req.resp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (grant_hit) begin
            conv.number  <= req.req_number[grant_idx*WIDTH +: WIDTH];
            winner       <= grant_idx;
            conv.restart <= 1'b1;
            busy         <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          // done may still be high from the last run on the first cycle
          if (conv.done && timer != '0) begin
            req.resp_digits <= conv.digits;
            req.resp_error  <= 1'b0;
            req.resp_valid  <= winner_oh;
            state           <= RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            req.resp_digits <= '0;
            req.resp_error  <= 1'b1;
            req.resp_valid  <= winner_oh;
            state           <= RESP;
          end
        end
        RESP: begin
          ptr   <= (winner == PW'(N_REQ - 1)) ? '0 : winner + 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_notation_arbiter.sv
// Directed bench for notation_arbiter with a scoreboard of expected
// responses and a behavioural converter model.
module tb_notation_arbiter;

  localparam int N_REQ   = 4;
  localparam int WIDTH   = 8;
  localparam int DIG_W   = 24;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  notation_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .DIG_W(DIG_W)) rq ();
  notation_conv_if #(.WIDTH(WIDTH), .DIG_W(DIG_W)) cv ();

  notation_arbiter #(
    .N_REQ(N_REQ), .WIDTH(WIDTH), .DIG_W(DIG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(rq),
    .conv(cv),
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_resp = 0;
  int n_restart = 0;

  // converter model: 0 normal, 1 done stuck high, 2 never done
  int conv_mode = 0;
  int conv_delay = 2;
  int cnt = 0;

  typedef struct {
    int               idx;
    logic [DIG_W-1:0] dig;
    logic             err;
    int               lat;
    int               acc;
  } exp_t;

  exp_t sbq[$];

  function automatic logic [DIG_W-1:0] bcd(input logic [7:0] n);
    logic [7:0] h, t, o;
    h = n / 8'd100;
    t = (n / 8'd10) % 8'd10;
    o = n % 8'd10;
    return {h, t, o};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  assign cv.digits = bcd(cv.number);

  initial cv.done = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cv.restart) begin
      cnt <= conv_delay;
      if (conv_mode != 1) cv.done <= 1'b0;
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end else if (cnt == 1) begin
      cnt <= 0;
      if (conv_mode != 2) cv.done <= 1'b1;
    end
  end

  // Monitor: push on accept, pop and compare on response.
  always @(negedge clk) begin
    #2;
    if (reset_n) begin
      if (cv.restart) n_restart++;
      if (rq.req_ready != '0) begin
        exp_t e;
        e.idx = 0;
        for (int i = 0; i < N_REQ; i++)
          if (rq.req_ready[i]) e.idx = i;
        e.err = (conv_mode == 2);
        e.dig = e.err ? '0 : bcd(rq.req_number[e.idx*WIDTH +: WIDTH]);
        e.lat = (conv_mode == 0) ? conv_delay + 3 :
                (conv_mode == 1) ? 4 : TIMEOUT + 2;
        e.acc = cyc;
        sbq.push_back(e);
      end
      if (rq.resp_valid != '0) begin
        n_resp++;
        chk("resp_expected", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          exp_t e;
          logic [N_REQ-1:0] oh;
          e = sbq.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          chk("resp_valid", rq.resp_valid, oh);
          chk("resp_digits", rq.resp_digits, e.dig);
          chk("resp_error", rq.resp_error, e.err);
          chk("resp_latency", cyc - e.acc, e.lat);
        end
      end
    end
  end

  // Called right at a falling edge; checks this cycle first.
  task automatic expect_accept(input string tag, input logic [N_REQ-1:0] exp,
                               input int maxc);
    int k;
    k = 0;
    #1;
    while (rq.req_ready == '0 && k < maxc) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, rq.req_ready, exp);
  endtask

  task automatic drain(input string tag, input int maxc);
    int k;
    k = 0;
    while ((sbq.size() != 0 || busy) && k < maxc) begin
      @(negedge clk);
      #3;
      k++;
    end
    chk(tag, (sbq.size() == 0) && !busy, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    rq.req_valid = '0;
    sbq.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int r0, p0;
    rq.req_valid  = '0;
    rq.req_number = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", rq.req_ready, 0);
    chk("rst_resp_valid", rq.resp_valid, 0);
    chk("rst_digits", rq.resp_digits, 0);
    chk("rst_error", rq.resp_error, 0);
    chk("rst_number", cv.number, 0);
    chk("rst_restart", cv.restart, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // single request, operand changed after accept
    @(negedge clk);
    conv_mode = 0;
    conv_delay = 2;
    r0 = n_restart;
    p0 = n_resp;
    rq.req_number = {8'd0, 8'd0, 8'd0, 8'd255};
    rq.req_valid = 4'b0001;
    expect_accept("t1_ready", 4'b0001, 4);
    @(negedge clk);
    rq.req_valid = '0;
    rq.req_number[7:0] = 8'd7;
    #1;
    chk("t1_restart_on", cv.restart, 1);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    #1;
    chk("t1_restart_off", cv.restart, 0);
    chk("t1_conv_number", cv.number, 255);
    drain("t1_drain", 20);
    chk("t1_restart_cnt", n_restart - r0, 1);
    chk("t1_resp_cnt", n_resp - p0, 1);
    chk("t1_digits_held", rq.resp_digits, 24'h020505);

    // all four held: 0,1,2,3,0
    do_reset();
    @(negedge clk);
    rq.req_number = {8'd40, 8'd30, 8'd20, 8'd10};
    rq.req_valid = 4'b1111;
    expect_accept("t2_g0", 4'b0001, 2);
    @(negedge clk);
    expect_accept("t2_g1", 4'b0010, 20);
    @(negedge clk);
    expect_accept("t2_g2", 4'b0100, 20);
    @(negedge clk);
    expect_accept("t2_g3", 4'b1000, 20);
    @(negedge clk);
    expect_accept("t2_g0b", 4'b0001, 20);
    @(negedge clk);
    rq.req_valid = '0;
    drain("t2_drain", 30);

    // serve req1 -> ptr=2, then 0011 wraps to req0
    @(negedge clk);
    rq.req_valid = 4'b0010;
    expect_accept("t3_r1", 4'b0010, 2);
    @(negedge clk);
    rq.req_valid = '0;
    drain("t3_drain1", 20);
    @(negedge clk);
    rq.req_valid = 4'b0011;
    expect_accept("t3_wrap", 4'b0001, 2);
    @(negedge clk);
    expect_accept("t3_next", 4'b0010, 20);
    @(negedge clk);
    rq.req_valid = '0;
    drain("t3_drain2", 20);

    // stale done high: must answer at t+4, not t+3
    chk("t4_done_stale", cv.done, 1);
    conv_mode = 1;
    conv_delay = 5;
    @(negedge clk);
    rq.req_valid = 4'b0100;
    expect_accept("t4_ready", 4'b0100, 2);
    @(negedge clk);
    rq.req_valid = '0;
    drain("t4_drain", 20);

    // timeout then a good conversion
    conv_mode = 2;
    @(negedge clk);
    rq.req_valid = 4'b1000;
    expect_accept("t5_ready", 4'b1000, 2);
    @(negedge clk);
    rq.req_valid = '0;
    drain("t5_drain", 90);
    chk("t5_err_held", rq.resp_error, 1);
    chk("t5_dig_held", rq.resp_digits, 0);
    conv_mode = 0;
    conv_delay = 3;
    @(negedge clk);
    rq.req_number[7:0] = 8'd99;
    rq.req_valid = 4'b0001;
    expect_accept("t5_next", 4'b0001, 2);
    @(negedge clk);
    rq.req_valid = '0;
    drain("t5_drain2", 20);
    chk("t5_err_clr", rq.resp_error, 0);
    chk("t5_dig_99", rq.resp_digits, 24'h000909);

    // reset in WAIT aborts the request
    conv_mode = 2;
    @(negedge clk);
    rq.req_number[23:16] = 8'd123;
    rq.req_valid = 4'b0100;
    expect_accept("t6_ready", 4'b0100, 2);
    @(negedge clk);
    rq.req_valid = '0;
    p0 = n_resp;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    sbq.delete();
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_resp_valid", rq.resp_valid, 0);
    chk("t6_digits", rq.resp_digits, 0);
    chk("t6_error", rq.resp_error, 0);
    chk("t6_number", cv.number, 0);
    chk("t6_restart", cv.restart, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_no_resp", n_resp - p0, 0);
    conv_mode = 0;
    conv_delay = 2;
    rq.req_valid = 4'b1111;
    expect_accept("t6_ptr0", 4'b0001, 2);
    @(negedge clk);
    rq.req_valid = '0;
    drain("t6_drain", 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
